// File: rtl/par_to_serial.sv
// ---------------------------------------------------------------------------
// par_to_serial
//
// Parallel-to-serial transmitter stage. Takes one byte from the upstream mux
// every 8 clocks and shifts it out MSB first on a single-bit lane. After every
// reset it first sends SYNC_SYMBOLS idle/COM symbols. Once that sync sequence
// is done it sends dataIn when validIn is high, and IDLE_BYTE otherwise.
//
// Ports
//   clk       in   1  single clock, rising edge
//   reset     in   1  asynchronous, active-low reset
//   dataIn    in   8  parallel byte, sampled only at load edges
//   validIn   in   1  dataIn qualifier, sampled only at load edges
//   dataOut   out  1  registered serial bit, MSB of each symbol first
//   frameOut  out  1  registered, high while dataOut carries bit 7 of a symbol
//   loadOut   out  1  combinational, high when the next edge samples dataIn
//   syncDone  out  1  registered, high once the last sync symbol is loaded
// ---------------------------------------------------------------------------
module par_to_serial #(
    parameter logic [7:0]  IDLE_BYTE    = 8'hBC,
    parameter int unsigned SYNC_SYMBOLS = 4        // legal range 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dataIn,
    input  logic       validIn,
    output logic       dataOut,
    output logic       frameOut,
    output logic       loadOut,
    output logic       syncDone
);

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [7:0] SYNC_LAST = 8'(SYNC_SYMBOLS - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] sym_cnt_q, sym_cnt_d;
    logic       data_q, data_d;
    logic       frame_q, frame_d;
    logic       sync_done_q, sync_done_d;

    logic       load_edge;
    logic [7:0] sel_byte;

    // cnt==7 marks the last bit of the current symbol, so the next edge loads.
    // Reset parks cnt at 7, which makes the first edge after release a load edge.
    assign load_edge = (cnt_q == 3'd7);

    // Input data is never selected during sync, whatever validIn says.
    assign sel_byte = (state_q == ST_RUN && validIn) ? dataIn : IDLE_BYTE;

    always_comb begin
        // NOTE: every signal gets a default here first, so no path through the
        // block can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q + 3'd1;
        sh_d        = {sh_q[6:0], 1'b0};
        sym_cnt_d   = sym_cnt_q;
        data_d      = sh_q[7];
        frame_d     = 1'b0;
        sync_done_d = sync_done_q;

        if (load_edge) begin
            data_d  = sel_byte[7];
            sh_d    = {sel_byte[6:0], 1'b0};
            frame_d = 1'b1;
            cnt_d   = 3'd0;

            if (state_q == ST_SYNC) begin
                sym_cnt_d = sym_cnt_q + 8'd1;
                if (sym_cnt_q == SYNC_LAST) begin
                    state_d     = ST_RUN;
                    sync_done_d = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its pre-edge value of the others. The reset is asynchronous, and
    // it clears the lane and restarts the sync sequence without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_SYNC;
            cnt_q       <= 3'd7;
            sh_q        <= 8'h00;
            sym_cnt_q   <= 8'h00;
            data_q      <= 1'b0;
            frame_q     <= 1'b0;
            sync_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            sym_cnt_q   <= sym_cnt_d;
            data_q      <= data_d;
            frame_q     <= frame_d;
            sync_done_q <= sync_done_d;
        end
    end

    assign dataOut  = data_q;
    assign frameOut = frame_q;
    assign syncDone = sync_done_q;
    // Gated by reset so that loadOut drops immediately while reset is held.
    assign loadOut  = reset && load_edge && (state_q == ST_RUN);

endmodule

// File: tb/tb_par_to_serial.sv
// ---------------------------------------------------------------------------
// tb_par_to_serial
//
// Self-checking bench for par_to_serial. Inputs change 1 time unit after a
// rising edge, and outputs are sampled at that same point. Expected values are
// hand-computed constants held in a vector table and in the directed sequences.
// ---------------------------------------------------------------------------
module tb_par_to_serial;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dataIn;
    logic       validIn;
    logic       dataOut;
    logic       frameOut;
    logic       loadOut;
    logic       syncDone;

    int n_checks = 0;
    int n_errors = 0;

    par_to_serial dut (
        .clk      (clk),
        .reset    (reset),
        .dataIn   (dataIn),
        .validIn  (validIn),
        .dataOut  (dataOut),
        .frameOut (frameOut),
        .loadOut  (loadOut),
        .syncDone (syncDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [7:0] exp_byte;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shifts one symbol out over 8 edges, checking each bit and the frame
    // marker. When glitch_at >= 0, the inputs change after the edge that
    // leaves cnt == glitch_at, which is mid-symbol.
    task automatic shift_check(input logic [7:0] exp, input int glitch_at,
                               input logic gv, input logic [7:0] gd, input string tag);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("%s bit%0d", tag, 7 - i), {7'd0, dataOut}, {7'd0, exp[7 - i]});
            check($sformatf("%s frame%0d", tag, i), {7'd0, frameOut}, {7'd0, (i == 0)});
            if (i == glitch_at) begin
                validIn = gv;
                dataIn  = gd;
            end
        end
    endtask

    task automatic send_symbol(input logic v, input logic [7:0] d, input logic [7:0] exp,
                               input int glitch_at, input logic gv, input logic [7:0] gd,
                               input string tag);
        check({tag, " loadOut"}, {7'd0, loadOut}, 8'd1);
        validIn = v;
        dataIn  = d;
        shift_check(exp, glitch_at, gv, gd, tag);
    endtask

    // Expects reset to have just been released 1 unit after an edge. Checks
    // edges 1..32: four BC symbols, the frame pulses, when syncDone rises,
    // and that loadOut goes high only after edge 32.
    task automatic check_sync(input string tag);
        logic [7:0] idle;
        idle = 8'hBC;
        check({tag, " loadOut pre"}, {7'd0, loadOut}, 8'd0);
        for (int e = 1; e <= 32; e++) begin
            step();
            check($sformatf("%s e%0d data", tag, e), {7'd0, dataOut}, {7'd0, idle[7 - ((e - 1) % 8)]});
            check($sformatf("%s e%0d frame", tag, e), {7'd0, frameOut}, {7'd0, ((e - 1) % 8 == 0)});
            check($sformatf("%s e%0d syncDone", tag, e), {7'd0, syncDone}, {7'd0, (e >= 25)});
            check($sformatf("%s e%0d loadOut", tag, e), {7'd0, loadOut}, {7'd0, (e == 32)});
        end
    endtask

    vec_t vecs[6];

    initial begin
        // Back-to-back table applied straight after sync with no gaps. It
        // starts with the held 55 byte and includes an idle insertion.
        vecs[0] = '{1'b1, 8'h55, 8'h55};
        vecs[1] = '{1'b1, 8'hA5, 8'hA5};
        vecs[2] = '{1'b0, 8'hFF, 8'hBC};
        vecs[3] = '{1'b1, 8'h00, 8'h00};
        vecs[4] = '{1'b1, 8'hFF, 8'hFF};
        vecs[5] = '{1'b1, 8'h81, 8'h81};

        validIn = 1'b1;
        dataIn  = 8'h55;
        reset   = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst dataOut", {7'd0, dataOut}, 8'd0);
        check("rst frameOut", {7'd0, frameOut}, 8'd0);
        check("rst syncDone", {7'd0, syncDone}, 8'd0);
        check("rst loadOut", {7'd0, loadOut}, 8'd0);
        step();
        step();
        reset = 1'b1;

        check_sync("sync1");

        for (int k = 0; k < 6; k++)
            send_symbol(vecs[k].valid, vecs[k].data, vecs[k].exp_byte, -1, 1'b0, 8'h00,
                        $sformatf("vec%0d", k));

        // Mid-symbol glitch: dataIn changes 3C->C3 at cnt=3. The in-flight
        // symbol is unaffected, and the next load picks up C3.
        send_symbol(1'b1, 8'h3C, 8'h3C, 3, 1'b1, 8'hC3, "glitch");
        check("glitch2 loadOut", {7'd0, loadOut}, 8'd1);
        shift_check(8'hC3, -1, 1'b0, 8'h00, "glitch2");

        // validIn toggles low then high inside the loadOut cycle, so only
        // the value present at the edge counts.
        check("toggle loadOut", {7'd0, loadOut}, 8'd1);
        validIn = 1'b0;
        dataIn  = 8'h96;
        #2 validIn = 1'b1;
        shift_check(8'h96, -1, 1'b0, 8'h00, "toggle");

        // Reset in the middle of A5, while dataOut=1 and syncDone=1.
        check("mid loadOut", {7'd0, loadOut}, 8'd1);
        validIn = 1'b1;
        dataIn  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mid bit%0d", 7 - i), {7'd0, dataOut}, {7'd0, 8'hA5 >> (7 - i) & 8'h01});
        end
        check("mid syncDone pre", {7'd0, syncDone}, 8'd1);
        reset = 1'b0;
        #1;
        check("mid rst dataOut", {7'd0, dataOut}, 8'd0);
        check("mid rst frameOut", {7'd0, frameOut}, 8'd0);
        check("mid rst syncDone", {7'd0, syncDone}, 8'd0);
        check("mid rst loadOut", {7'd0, loadOut}, 8'd0);
        step();
        check("mid rst hold dataOut", {7'd0, dataOut}, 8'd0);
        check("mid rst hold loadOut", {7'd0, loadOut}, 8'd0);
        reset = 1'b1;

        check_sync("sync2");
        send_symbol(1'b1, 8'hA5, 8'hA5, -1, 1'b0, 8'h00, "after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Backstop so the run always ends, even if the initial block stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary, expected completion");
        $fatal(1, "timeout");
    end

endmodule
